// File: rtl/bcd_tick_counter_pkg.sv
// Shared definitions for the single-digit BCD stopwatch counter and its decoder.
// BCD_BLANK is the decoder's blank code; the counter never drives it.
package bcd_tick_counter_pkg;

    typedef enum logic {
        ST_STOP = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam logic [3:0] BCD_MAX   = 4'd9;
    localparam logic [3:0] BCD_BLANK = 4'hF;

    // Wraps at BCD_MAX so codes 10..15 can never be produced.
    function automatic logic [3:0] bcdInc(input logic [3:0] digit);
        return (digit >= BCD_MAX) ? 4'd0 : digit + 4'd1;
    endfunction

endpackage

// File: rtl/bcd_tick_counter_btn_conditioner.sv
// Push-button conditioner: 2-FF synchronizer, optional debounce and rising-edge pulse.
// The debounce filter is built only when BCD_CNT_DEBOUNCE_EN is defined.
module btn_conditioner #(
    parameter int DEB_CYCLES = 500_000
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_btn,
    output logic o_pulse
);

    logic sync1_q;
    logic sync2_q;
    logic level;
    logic prev_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= i_btn;
            sync2_q <= sync1_q;
            prev_q  <= level;
        end
    end

`ifdef BCD_CNT_DEBOUNCE_EN
    localparam int DEB_W = $clog2(DEB_CYCLES + 1);

    logic [DEB_W-1:0] debCnt_q;
    logic [DEB_W-1:0] debCnt_d;
    logic             accepted_q;
    logic             accepted_d;

    // A new level is taken only after DEB_CYCLES consecutive samples that disagree with it.
    always_comb begin
        debCnt_d   = '0;
        accepted_d = accepted_q;
        if (sync2_q != accepted_q) begin
            if (debCnt_q == DEB_W'(DEB_CYCLES - 1)) begin
                accepted_d = sync2_q;
            end else begin
                debCnt_d = debCnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            debCnt_q   <= '0;
            accepted_q <= 1'b0;
        end else begin
            debCnt_q   <= debCnt_d;
            accepted_q <= accepted_d;
        end
    end

    assign level = accepted_q;
`else
    assign level = sync2_q;
`endif

    assign o_pulse = level & ~prev_q;

endmodule

// File: rtl/bcd_tick_counter.sv
// Single-digit run/stop BCD counter with prescaled tick and cascade carry.
// Define BCD_CNT_DEBOUNCE_EN to debounce the run/stop button.
module bcd_tick_counter
    import bcd_tick_counter_pkg::*;
#(
    parameter int TICK_DIV   = 50_000_000,
    parameter int DEB_CYCLES = 500_000
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_btn,
    input  logic       i_clear,
    output logic [3:0] o_digit,
    output logic       o_carry,
    output logic       o_running
);

    localparam int              PRE_W    = $clog2(TICK_DIV);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

    state_t            state_q;
    state_t            state_d;
    logic [PRE_W-1:0]  pre_q;
    logic [PRE_W-1:0]  pre_d;
    logic [3:0]        digit_q;
    logic [3:0]        digit_d;
    logic              carry_q;
    logic              carry_d;
    logic              btnPulse;
    logic              tick;

    btn_conditioner #(
        .DEB_CYCLES(DEB_CYCLES)
    ) u_btn (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_btn  (i_btn),
        .o_pulse(btnPulse)
    );

    always_comb begin
        state_d = state_q;
        if (btnPulse) begin
            state_d = (state_q == ST_RUN) ? ST_STOP : ST_RUN;
        end
    end

    // Tick uses the current state, so a press coinciding with a tick still lets it count.
    always_comb begin
        tick    = (state_q == ST_RUN) && (pre_q == PRE_LAST);
        pre_d   = pre_q;
        digit_d = digit_q;
        carry_d = 1'b0;
        if (i_clear) begin
            pre_d   = '0;
            digit_d = '0;
        end else if (state_q == ST_RUN) begin
            pre_d = tick ? '0 : pre_q + 1'b1;
            if (tick) begin
                digit_d = bcdInc(digit_q);
                carry_d = (digit_q >= BCD_MAX);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= ST_STOP;
            pre_q   <= '0;
            digit_q <= '0;
            carry_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pre_q   <= pre_d;
            digit_q <= digit_d;
            carry_q <= carry_d;
        end
    end

    assign o_digit   = digit_q;
    assign o_carry   = carry_q;
    assign o_running = (state_q == ST_RUN);

endmodule

// File: tb/tb_bcd_tick_counter.sv
// Directed bench for bcd_tick_counter with TICK_DIV=4, DEB_CYCLES=3.
// Expectations adapt to BCD_CNT_DEBOUNCE_EN when the bench is built with it.
module tb_bcd_tick_counter;

    localparam int TICK_DIV   = 4;
    localparam int DEB_CYCLES = 3;

`ifdef BCD_CNT_DEBOUNCE_EN
    localparam int         LAT        = 6;
    localparam int         PRESS_OFS  = 1;
    localparam logic [3:0] STOP_DIGIT = 4'd2;
    localparam logic       GLITCH_RUN = 1'b1;
`else
    localparam int         LAT        = 3;
    localparam int         PRESS_OFS  = 0;
    localparam logic [3:0] STOP_DIGIT = 4'd1;
    localparam logic       GLITCH_RUN = 1'b0;
`endif

    logic       i_clk = 1'b0;
    logic       i_rst;
    logic       i_btn;
    logic       i_clear;
    logic [3:0] o_digit;
    logic       o_carry;
    logic       o_running;

    int checks = 0;
    int errors = 0;

    bcd_tick_counter #(
        .TICK_DIV  (TICK_DIV),
        .DEB_CYCLES(DEB_CYCLES)
    ) dut (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_btn    (i_btn),
        .i_clear  (i_clear),
        .o_digit  (o_digit),
        .o_carry  (o_carry),
        .o_running(o_running)
    );

    always #5 i_clk = ~i_clk;

    task automatic applyStimulus(input logic btn, input logic clear, input int cycles);
        i_btn   = btn;
        i_clear = clear;
        repeat (cycles) begin
            @(posedge i_clk);
            #1;
        end
    endtask

    task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    initial begin
        i_rst   = 1'b1;
        i_btn   = 1'b0;
        i_clear = 1'b0;
        applyStimulus(1'b0, 1'b0, 2);
        checkOutput("reset_outputs", {2'b0, o_digit, o_carry, o_running}, 8'd0);
        i_rst = 1'b0;

        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b0, 1'b0, 1);
            checkOutput("idle_outputs", {2'b0, o_digit, o_carry, o_running}, 8'd0);
        end

        applyStimulus(1'b1, 1'b0, LAT - 1);
        checkOutput("start_early", {7'b0, o_running}, 8'd0);
        applyStimulus(1'b1, 1'b0, 1);
        checkOutput("start_latency", {7'b0, o_running}, 8'd1);

        for (int d = 1; d <= 9; d++) begin
            applyStimulus(1'b0, 1'b0, 3);
            checkOutput("count_hold", {4'b0, o_digit}, 8'(d - 1));
            applyStimulus(1'b0, 1'b0, 1);
            checkOutput("count_step", {4'b0, o_digit}, 8'(d));
            checkOutput("count_carry", {7'b0, o_carry}, 8'd0);
            checkOutput("count_running", {7'b0, o_running}, 8'd1);
        end

        applyStimulus(1'b0, 1'b0, 3);
        checkOutput("wrap_pre_digit", {4'b0, o_digit}, 8'd9);
        checkOutput("wrap_pre_carry", {7'b0, o_carry}, 8'd0);
        applyStimulus(1'b0, 1'b0, 1);
        checkOutput("wrap_digit", {4'b0, o_digit}, 8'd0);
        checkOutput("wrap_carry", {7'b0, o_carry}, 8'd1);
        applyStimulus(1'b0, 1'b0, 1);
        checkOutput("wrap_carry_drop", {7'b0, o_carry}, 8'd0);
        checkOutput("wrap_post_digit", {4'b0, o_digit}, 8'd0);

        applyStimulus(1'b0, 1'b0, 22);
        checkOutput("clear_pre_digit", {4'b0, o_digit}, 8'd5);
        applyStimulus(1'b0, 1'b1, 1);
        checkOutput("clear_digit", {4'b0, o_digit}, 8'd0);
        checkOutput("clear_carry", {7'b0, o_carry}, 8'd0);
        checkOutput("clear_running", {7'b0, o_running}, 8'd1);
        applyStimulus(1'b0, 1'b0, 3);
        checkOutput("clear_hold", {4'b0, o_digit}, 8'd0);
        applyStimulus(1'b0, 1'b0, 1);
        checkOutput("clear_resume", {4'b0, o_digit}, 8'd1);

        applyStimulus(1'b0, 1'b0, PRESS_OFS);
        applyStimulus(1'b1, 1'b0, LAT - 1);
        checkOutput("stop_early", {7'b0, o_running}, 8'd1);
        applyStimulus(1'b1, 1'b0, 1);
        checkOutput("stop_running", {7'b0, o_running}, 8'd0);
        checkOutput("stop_digit", {4'b0, o_digit}, {4'b0, STOP_DIGIT});
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b0, 1'b0, 1);
            checkOutput("frozen_digit", {4'b0, o_digit}, {4'b0, STOP_DIGIT});
            checkOutput("frozen_running", {7'b0, o_running}, 8'd0);
        end
        applyStimulus(1'b1, 1'b0, LAT - 1);
        checkOutput("restart_early", {7'b0, o_running}, 8'd0);
        applyStimulus(1'b1, 1'b0, 1);
        checkOutput("restart_running", {7'b0, o_running}, 8'd1);
        checkOutput("restart_digit", {4'b0, o_digit}, {4'b0, STOP_DIGIT});
        applyStimulus(1'b1, 1'b0, 1);
        checkOutput("resume_step", {4'b0, o_digit}, {4'b0, STOP_DIGIT + 4'd1});

        applyStimulus(1'b0, 1'b0, 12);
        checkOutput("release_no_event", {7'b0, o_running}, 8'd1);
        applyStimulus(1'b1, 1'b0, 2);
        applyStimulus(1'b0, 1'b0, 10);
        checkOutput("glitch_running", {7'b0, o_running}, {7'b0, GLITCH_RUN});

        applyStimulus(1'b0, 1'b1, 1);
        checkOutput("clear_keeps_state", {7'b0, o_running}, {7'b0, GLITCH_RUN});
        checkOutput("clear_digit_any", {4'b0, o_digit}, 8'd0);

        i_rst = 1'b1;
        applyStimulus(1'b0, 1'b0, 1);
        checkOutput("midrun_reset", {2'b0, o_digit, o_carry, o_running}, 8'd0);
        i_rst = 1'b0;
        applyStimulus(1'b0, 1'b0, 2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
